nibble_serial_add_ctrl: RTL and testbench

- Sequencer that adds two WIDTH-bit operands using a single instance of the team's existing 4-bit ripple-carry adder, RCA_4bit.
- Processes one nibble per clock, least-significant nibble first; the carry is registered between nibbles.
- Sits between a requester (valid/ready input) and a consumer (valid/ready output).
- Trades latency for area in wide-add paths.

---
 rtl/nibble_add_pkg.sv | 29 ++
 rtl/RCA_4bit.sv | 29 ++
 rtl/nibble_serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/nibble_add_pkg.sv
// ============================================================================
// Module  : nibble_add_pkg
// Purpose : Shared state encoding and sizing helpers for the nibble-serial adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package nibble_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ADD  = ST_ADD,
    S_DONE = ST_DONE
  } state_t;

  // A single-nibble datapath still needs a 1-bit index register.
  function automatic int idx_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

`default_nettype wire

// File: rtl/RCA_4bit.sv
// ============================================================================
// Module  : RCA_4bit
// Purpose : 4-bit ripple-carry adder, sum = A + B + cin.
// Revision: 1.0
// ============================================================================
`default_nettype none

module RCA_4bit (
  input  logic       cin,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       cout,
  output logic [3:0] sum
);

  logic [4:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]    = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1]  = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
  end

  assign cout = w_c[4];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
// ============================================================================
// Module  : nibble_serial_add_ctrl
// Purpose : WIDTH-bit add done one nibble per clock through a single RCA_4bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  import nibble_add_pkg::*;

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIB - 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_carry;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_sum;
  logic                r_cout;
  logic                r_out_valid;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_rca_sum;
  logic                w_rca_cout;

  // Nibble select driven purely from registered operands and index.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int n = 0; n < NIB; n++) begin
      if (r_idx == IDX_W'(n)) begin
        w_a_nib = r_a[n*NIBBLE_W +: NIBBLE_W];
        w_b_nib = r_b[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  RCA_4bit u_rca (
    .cin  (r_carry),
    .A    (w_a_nib),
    .B    (w_b_nib),
    .cout (w_rca_cout),
    .sum  (w_rca_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          for (int n = 0; n < NIB; n++) begin
            if (r_idx == IDX_W'(n)) begin
              r_sum[n*NIBBLE_W +: NIBBLE_W] <= w_rca_sum;
            end
          end
          r_carry <= w_rca_cout;
          if (r_idx == C_LAST_IDX) begin
            r_cout      <= w_rca_cout;
            r_out_valid <= 1'b1;
            r_idx       <= '0;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          // Result stays presented until the consumer takes it.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_ADD) || (r_state == S_DONE);
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
// ============================================================================
// Module  : tb_nibble_serial_add_ctrl
// Purpose : Scoreboard bench for 16-bit and 4-bit nibble-serial adders.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, cin16, cout16, busy16;
  logic [15:0] a16, b16, sum16;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4, busy4;
  logic [3:0]  a4, b4, sum4;

  int total = 0;
  int bad   = 0;

  logic [16:0] q16[$];
  logic [4:0]  q4[$];

  nibble_serial_add_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .busy(busy16)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
    check_val("in_ready16_pre", 32'(in_ready16), 32'd1);
    a16 = ta; b16 = tb_v; cin16 = tc; in_valid16 = 1'b1;
    q16.push_back({1'b0, ta} + {1'b0, tb_v} + {16'b0, tc});
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    check_val("busy16_add", 32'(busy16), 32'd1);
  endtask

  task automatic wait16(input int exp_lat, input bit scramble);
    int n;
    logic [16:0] exp;
    n = 0;
    while (!out_valid16 && n < 40) begin
      if (scramble) begin
        a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    check_val("lat16", 32'(n), 32'(exp_lat));
    exp = (q16.size() != 0) ? q16.pop_front() : 17'h0;
    check_val("sum16", 32'(sum16), 32'(exp[15:0]));
    check_val("cout16", 32'(cout16), 32'(exp[16]));
  endtask

  task automatic retire16();
    @(posedge clk); #1;
    check_val("out_valid16_drop", 32'(out_valid16), 32'd0);
    check_val("in_ready16_back", 32'(in_ready16), 32'd1);
    check_val("busy16_idle", 32'(busy16), 32'd0);
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc);
    int n;
    logic [4:0] exp;
    a4 = ta; b4 = tb_v; cin4 = tc; in_valid4 = 1'b1;
    q4.push_back({1'b0, ta} + {1'b0, tb_v} + {4'b0, tc});
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("lat4", 32'(n), 32'd1);
    exp = (q4.size() != 0) ? q4.pop_front() : 5'h0;
    check_val("sum4", 32'(sum4), 32'(exp[3:0]));
    check_val("cout4", 32'(cout4), 32'(exp[4]));
    @(posedge clk); #1;
    check_val("out_valid4_drop", 32'(out_valid4), 32'd0);
    check_val("in_ready4_back", 32'(in_ready4), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b1;
    in_valid4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0; out_ready4  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready16", 32'(in_ready16), 32'd1);
    check_val("rst_out_valid16", 32'(out_valid16), 32'd0);
    check_val("rst_sum16", 32'(sum16), 32'd0);
    check_val("rst_cout16", 32'(cout16), 32'd0);
    check_val("rst_busy16", 32'(busy16), 32'd0);
    check_val("rst_in_ready4", 32'(in_ready4), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic add and full carry chains
    issue16(16'h1234, 16'h4321, 1'b0); wait16(4, 1'b0); retire16();
    check_val("basic_sum_kept", 32'(sum16), 32'h5555);
    issue16(16'hFFFF, 16'h0001, 1'b0); wait16(4, 1'b0); retire16();
    issue16(16'hFFFF, 16'h0000, 1'b1); wait16(4, 1'b0); retire16();

    // Backpressure with an ignored request in DONE
    out_ready16 = 1'b0;
    issue16(16'h00F0, 16'h0F10, 1'b1); wait16(4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        a16 = 16'h1111; b16 = 16'h1111; in_valid16 = 1'b1;
      end else begin
        in_valid16 = 1'b0;
      end
      @(posedge clk); #1;
      check_val("bp_sum", 32'(sum16), 32'h1001);
      check_val("bp_cout", 32'(cout16), 32'd0);
      check_val("bp_out_valid", 32'(out_valid16), 32'd1);
      check_val("bp_in_ready", 32'(in_ready16), 32'd0);
    end
    in_valid16 = 1'b0;
    out_ready16 = 1'b1;
    retire16();
    check_val("bp_sum_kept", 32'(sum16), 32'h1001);

    // Reset in the middle of an add
    issue16(16'hABCD, 16'h1111, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_val("mid_rst_out_valid", 32'(out_valid16), 32'd0);
    check_val("mid_rst_sum", 32'(sum16), 32'd0);
    check_val("mid_rst_cout", 32'(cout16), 32'd0);
    check_val("mid_rst_busy", 32'(busy16), 32'd0);
    check_val("mid_rst_in_ready", 32'(in_ready16), 32'd1);
    void'(q16.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    issue16(16'h0001, 16'h0001, 1'b0); wait16(4, 1'b0); retire16();

    // Operands change during ADD
    for (int i = 0; i < 3; i++) begin
      issue16(16'($urandom), 16'($urandom), 1'($urandom));
      wait16(4, 1'b1);
      retire16();
    end

    // Narrow instance
    op4(4'hF, 4'h1, 1'b1);
    op4(4'h7, 4'h8, 1'b0);
    op4(4'h9, 4'h9, 1'b1);

    // Randomized sweep, some ops with delayed consumer
    for (int i = 0; i < 200; i++) begin
      int k;
      k = (i % 5 == 0) ? int'($urandom_range(1, 3)) : 0;
      if (k != 0) out_ready16 = 1'b0;
      issue16(16'($urandom), 16'($urandom), 1'($urandom));
      wait16(4, 1'b0);
      if (k != 0) begin
        repeat (k) @(posedge clk);
        #1;
        check_val("sweep_hold", 32'(out_valid16), 32'd1);
        out_ready16 = 1'b1;
      end
      retire16();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
